uart_reset_sequencer: RTL
=========================

// Module: uart_reset_sequencer
// PURPOSE
//   Staged reset generator for the UART-with-memory subsystem. Runs after the
//   reset synchronizer, in the opposite direction: it takes the clean system
//   reset plus a software reset request and drives per-block resets.
//   Holds all block resets for a fixed time, then releases them in order
//   (memory, then RX, then TX) and reports completion.
// PARAMETERS
//   HOLD_CYCLES  16  cycles all block resets stay asserted after a start (>=1)
//   STAGE_GAP    4   cycles between successive releases (>=1)
//   CW           8   counter width; must satisfy 2**CW > max(HOLD_CYCLES,STAGE_GAP)
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   reset       in   1  synchronous, active-high system reset (already synchronized)
//   sw_rst_req  in   1  software reset request; level input, rising edge triggers
//   rst_mem     out  1  active-high reset to memory block
//   rst_rx      out  1  active-high reset to UART receiver
//   rst_tx      out  1  active-high reset to UART transmitter
//   busy        out  1  high while any block reset is asserted
//   done        out  1  one-cycle pulse when the sequence completes
// BEHAVIOUR
//   Interface: one clock (clk); reset is synchronous and active-high.
//   - All outputs are registered. reset has priority over every other input.
//   - Reset values: rst_mem=rst_rx=rst_tx=1, busy=1, done=0, state=HOLD,
//     cnt=0, req_q=1. A request held high through reset is not an edge.
//   - Request edge: req_edge = sw_rst_req & ~req_q. req_q <= sw_rst_req each cycle.
//   - States: IDLE, HOLD, REL_MEM, REL_RX.
//     HOLD: all rst_*=1. cnt increments each cycle. When cnt==HOLD_CYCLES-1:
//       rst_mem<=0, cnt<=0, go to REL_MEM.
//     REL_MEM: rst_rx, rst_tx=1. When cnt==STAGE_GAP-1: rst_rx<=0, cnt<=0,
//       go to REL_RX.
//     REL_RX: rst_tx=1. When cnt==STAGE_GAP-1: rst_tx<=0, busy<=0, done<=1,
//       go to IDLE.
//     IDLE: all rst_*=0, busy=0. done=1 only in the first IDLE cycle.
//   - Start, from reset or req_edge: at that edge all rst_*<=1, busy<=1,
//     done<=0, cnt<=0, state<=HOLD.
//   - Timing, counting edge 1 as the first posedge sampling reset=0 (or the
//     edge after req_edge is sampled = edge 0):
//     rst_mem falls at edge HOLD_CYCLES;
//     rst_rx falls STAGE_GAP edges later;
//     rst_tx, busy fall, and done rises, STAGE_GAP edges after that.
//   - req_edge in any state restarts from HOLD, including mid-sequence.
//     Released resets are reasserted at that edge.
//   - req_edge on the same edge as the final release: the restart wins.
//     rst_tx stays 1, busy stays 1, no done pulse.
//   - reset mid-sequence: outputs return to reset values on that edge. The
//     full sequence reruns after reset drops. No done pulse for an aborted
//     sequence.
//   - cnt never exceeds max(HOLD_CYCLES,STAGE_GAP)-1. No wrap occurs.
// TESTING
//   1 Power-on: reset=1 for 3 cycles, then 0 -> rst_mem falls at edge 16,
//     rst_rx at 20, rst_tx/busy at 24, done=1 for exactly one cycle.
//   2 IDLE, sw_rst_req 0->1 sampled at edge n -> all rst_*=1 after n; releases
//     at n+16, n+20, n+24; one done pulse.
//   3 sw_rst_req rises during REL_MEM (sampled edge 18 after reset) ->
//     rst_mem=1 again after 18; releases at 34, 38, 42; one done pulse total.
//   4 sw_rst_req held high 60 cycles -> exactly one sequence. Held high through
//     reset -> no extra sequence.
//   5 reset reasserted at edge 22 -> all rst_*=1, busy=1, done=0 next cycle;
//     after release the sequence restarts from HOLD.
//   6 HOLD_CYCLES=1, STAGE_GAP=1 -> releases at edges 1, 2, 3. Also request
//     edge coincident with final release (edge 24) -> no done pulse, rst_tx=1.

Source files
------------

// File: rtl/uart_reset_sequencer.sv
// Staged block-reset generator: holds memory/RX/TX resets, then
// releases them in order and pulses done when the sequence completes.
module uart_reset_sequencer #(
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4,
   parameter int CW          = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_rst_req,
   output logic rst_mem,
   output logic rst_rx,
   output logic rst_tx,
   output logic busy,
   output logic done
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] HOLD    = 2'd1;
   localparam logic [1:0] REL_MEM = 2'd2;
   localparam logic [1:0] REL_RX  = 2'd3;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          req_q;
   logic          req_edge;

   assign req_edge = sw_rst_req & ~req_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= HOLD;
         cnt     <= '0;
         req_q   <= 1'b1;
         rst_mem <= 1'b1;
         rst_rx  <= 1'b1;
         rst_tx  <= 1'b1;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         req_q <= sw_rst_req;
         done  <= 1'b0;
         // A new request restarts the whole sequence, even mid-release
         if (req_edge) begin
            state   <= HOLD;
            cnt     <= '0;
            rst_mem <= 1'b1;
            rst_rx  <= 1'b1;
            rst_tx  <= 1'b1;
            busy    <= 1'b1;
         end else begin
            unique case (state)
               HOLD: begin
                  if (cnt == HOLD_LAST) begin
                     rst_mem <= 1'b0;
                     cnt     <= '0;
                     state   <= REL_MEM;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               REL_MEM: begin
                  if (cnt == GAP_LAST) begin
                     rst_rx <= 1'b0;
                     cnt    <= '0;
                     state  <= REL_RX;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               REL_RX: begin
                  if (cnt == GAP_LAST) begin
                     rst_tx <= 1'b0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     cnt    <= '0;
                     state  <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               IDLE: begin
                  cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule
